// File: rtl/mult4_share_arbiter.sv
// Round-robin arbiter sharing one registered 4x4 unsigned multiplier among NUM_REQ requesters.
// Accept in IDLE, product registered in MUL, held in RESP until rsp_ready.
module mult4_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_p,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_win_id;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic             w_win_vld;
  logic             w_accept;
  int               w_idx;
  int               w_nxt_idx;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic [7:0]       w_prod;
  logic [7:0]       r_rsp_p;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_valid;
  logic [CNT_W-1:0] r_op_count;

  // Descending scan so the requester closest to r_rr_ptr overwrites all others.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (req_valid[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = ID_W'(w_idx);
      end
    end
    w_nxt_idx = int'(w_win_id) + 1;
    if (w_nxt_idx >= NUM_REQ) w_nxt_idx = 0;
    w_ptr_nxt = ID_W'(w_nxt_idx);
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          req_ready[w_win_id] = 1'b1;
          w_state_nxt         = ST_MUL;
        end
      end
      ST_MUL:  w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_accept = (r_state == ST_IDLE) && w_win_vld;
  assign w_prod   = {4'b0000, r_op_a} * {4'b0000, r_op_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_p     <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= req_a[4*w_win_id +: 4];
        r_op_b   <= req_b[4*w_win_id +: 4];
        r_rsp_id <= w_win_id;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_MUL) begin
        r_rsp_p     <= w_prod;
        r_rsp_valid <= 1'b1;
      end
      if ((r_state == ST_RESP) && r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != ST_IDLE);
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_mult4_share_arbiter.sv
// Directed self-checking bench for mult4_share_arbiter (NUM_REQ=4).
module tb_mult4_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_p;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] op_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_g[5];
  int exp_p[5];

  mult4_share_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    req_valid          = 4'b0001 << id;
    req_a[4*id +: 4]   = a;
    req_b[4*id +: 4]   = b;
    #1 chk("op_grant", req_ready, 32'd1 << id);
    @(negedge clk);
    req_valid = '0;
    #1 chk("op_mul_novld", rsp_valid, 0);
    chk("op_mul_busy", busy, 1);
    @(negedge clk);
    #1 chk("op_rsp_vld", rsp_valid, 1);
    chk("op_rsp_p", rsp_p, exp);
    chk("op_rsp_id", rsp_id, id);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("op_done_vld", rsp_valid, 0);
    chk("op_done_busy", busy, 0);
  endtask

  task automatic rr_run(input logic [3:0] vld, input int n);
    int g    = 0;
    int r    = 0;
    int last = 0;
    rsp_ready = 1'b1;
    req_valid = vld;
    for (int cyc = 0; cyc < 40 && (g < n || r < n); cyc++) begin
      #1;
      if (req_ready != 4'b0000 && g < n) begin
        chk("rr_grant", req_ready, 32'd1 << exp_g[g]);
        if (g > 0) chk("rr_gap", cyc - last, 3);
        last = cyc;
        g++;
      end
      if (rsp_valid && r < n) begin
        chk("rr_p", rsp_p, exp_p[r]);
        chk("rr_id", rsp_id, exp_g[r]);
        r++;
      end
      @(negedge clk);
    end
    chk("rr_complete", g * 10 + r, n * 11);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("drain_idle", busy, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1 chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2, 4'd13, 4'd11, 8'd143);
    chk("t1_op_count", op_count, 1);

    do_reset();
    req_a = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b = {4'd3, 4'd3, 4'd3, 4'd3};
    exp_g = '{0, 1, 2, 3, 0};
    exp_p = '{3, 6, 9, 12, 3};
    rr_run(4'b1111, 5);
    drain();

    do_reset();
    exp_g = '{0, 2, 0, 2, 0};
    exp_p = '{3, 9, 3, 9, 3};
    rr_run(4'b0101, 4);
    drain();

    do_reset();
    req_valid    = 4'b0010;
    req_a[7:4]   = 4'd15;
    req_b[7:4]   = 4'd15;
    #1 chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_p", rsp_p, 225);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_rel_busy", busy, 0);
    chk("bp_rel_vld", rsp_valid, 0);
    chk("bp_rel_ready", req_ready, 4'b0001);
    chk("bp_op_count", op_count, 1);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);

    do_op(0, 4'd0, 4'd9, 8'd0);
    do_op(1, 4'd1, 4'd15, 8'd15);
    do_op(2, 4'd8, 4'd8, 8'd64);

    do_reset();
    req_valid  = 4'b0001;
    req_a[3:0] = 4'd5;
    req_b[3:0] = 4'd5;
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    #1 chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rsp_p", rsp_p, 0);
    chk("mrst_rsp_id", rsp_id, 0);
    chk("mrst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("mrst_no_rsp", rsp_valid, 0);
    chk("mrst_op_count", op_count, 0);
    req_valid = 4'b1001;
    #1 chk("mrst_ptr_zero", req_ready, 4'b0001);
    req_valid = '0;
    @(negedge clk);
    do_op(3, 4'd7, 4'd9, 8'd63);
    chk("mrst_op_count_after", op_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult4_share_arbiter.md
Name: mult4_share_arbiter

Overview:
- Shares one combinational 4x4 unsigned multiplier (A[3:0], B[3:0] -> P[7:0]) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake, registered operands and product, single-entry response port with backpressure.
- Sits between the requesting datapath stages and the multiplier, and is the only sequencer of that multiplier.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  4*NUM_REQ  operand A; requester i occupies bits [4i+3:4i].
- req_b  in  4*NUM_REQ  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot accept; handshake for requester i when req_valid[i] & req_ready[i].
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_p  out  8  registered product A*B.
- rsp_id  out  ID_W  index of the requester that owns rsp_p.
- busy  out  1  high in any state except IDLE.
- op_count  out  CNT_W  number of completed responses; wraps modulo 2**CNT_W.

Behaviour:
- Reset (async assert, sync-free): state=IDLE, rr_ptr=0, op_a=op_b=0, rsp_p=0, rsp_id=0, rsp_valid=0, busy=0, op_count=0, req_ready=0.
- FSM states: IDLE -> MUL -> RESP -> IDLE.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the handshake edge: op_a<=req_a[winner], op_b<=req_b[winner], rsp_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, state<=MUL.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- MUL: rsp_p<=multiplier(op_a,op_b), rsp_valid<=1, state<=RESP. req_ready=0.
- RESP:
  - rsp_valid=1; rsp_p and rsp_id held stable.
  - On rsp_valid&rsp_ready: rsp_valid<=0, op_count<=op_count+1, state<=IDLE.
  - Otherwise hold indefinitely.
  - req_ready=0.
- req_ready is nonzero only in IDLE.
- Latency: handshake at edge T -> rsp_valid high after edge T+1 (2nd cycle after accept). Peak throughput is one op per 3 cycles with rsp_ready held high.
- Requester rule: once req_valid is asserted, operands are held stable and valid is not dropped until the handshake. The block relies on this and does not check it.
- Arithmetic: unsigned; 15*15=225 fits 8 bits; no overflow possible.
- The new arbitration decision in IDLE uses the rr_ptr value already updated at the previous grant, so a requester that was just served ranks lowest.
- rst_n asserted mid-operation: immediate return to reset values. The in-flight result is discarded with no response, and the requester reissues.
- A requester dropping req_valid in IDLE before the handshake is simply not granted.
- NUM_REQ=1 is not supported.

Test Plan:
- Reset then single request, req 2: A=13, B=11 -> req_ready=4'b0100 same cycle; rsp_valid 2 cycles later with rsp_p=143 (0x8F), rsp_id=2; op_count=1 after rsp handshake.
- All four valid continuously, rsp_ready=1, A=i+1, B=3 -> grant order 0,1,2,3,0; products 3,6,9,12,3; one accept every 3 cycles.
- Requesters 0 and 2 permanently valid -> grants alternate 0,2,0,2; requesters 1 and 3 never granted while idle.
- Backpressure: A=15, B=15, rsp_ready low for 5 cycles -> rsp_valid stays 1, rsp_p=225 stable, req_ready=0 throughout, busy=1; release -> IDLE next cycle.
- Edge operands: A=0, B=9 -> 0; A=1, B=15 -> 15; A=8, B=8 -> 64.
- rst_n pulsed low while in MUL -> rsp_valid never rises, all outputs zero, rr_ptr=0; next request from req 3 -> granted, correct product.
